// File: rtl/timer.sv
//----------------------------------------------------------------------------
// Module  : timer
// Brief   : Free-running clock divider; one-clock carry pulse on each wrap.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module timer #(
  parameter logic [31:0] cycle = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        cy,
  output logic [31:0] cnt
);

  // A period of 0 behaves like 1: the counter never leaves zero.
  localparam logic [31:0] c_last = (cycle <= 32'd1) ? 32'd0 : (cycle - 32'd1);

  logic [31:0] r_cnt;
  logic        r_cy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 32'd0;
      r_cy  <= 1'b0;
    end else if (r_cnt == c_last) begin
      r_cnt <= 32'd0;
      r_cy  <= 1'b1;
    end else begin
      r_cnt <= r_cnt + 32'd1;
      r_cy  <= 1'b0;
    end
  end

  assign cnt = r_cnt;
  assign cy  = r_cy;

endmodule

`default_nettype wire

// File: tb/tb_timer.sv
//----------------------------------------------------------------------------
// Module  : tb_timer
// Brief   : Scoreboard bench for timer across several periods (5,1,2,41667,0).
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_timer;

  localparam int c_n = 5;

  typedef struct {
    int          d;
    logic [31:0] c;
    logic        y;
  } exp_t;

  logic              clk = 1'b0;
  logic [c_n-1:0]    rst_v = '1;
  logic [31:0]       cnt_o [c_n];
  logic              cy_o  [c_n];

  longint unsigned   cyc_eff [c_n] = '{5, 1, 2, 41667, 1};
  longint unsigned   k [c_n];
  exp_t              q [$];
  int                total = 0;
  int                bad   = 0;

  always #5 clk = ~clk;

  timer #(.cycle(32'd5))     u_t5  (.clk(clk), .rst(rst_v[0]), .cy(cy_o[0]), .cnt(cnt_o[0]));
  timer #(.cycle(32'd1))     u_t1  (.clk(clk), .rst(rst_v[1]), .cy(cy_o[1]), .cnt(cnt_o[1]));
  timer #(.cycle(32'd2))     u_t2  (.clk(clk), .rst(rst_v[2]), .cy(cy_o[2]), .cnt(cnt_o[2]));
  timer #(.cycle(32'd41667)) u_tl  (.clk(clk), .rst(rst_v[3]), .cy(cy_o[3]), .cnt(cnt_o[3]));
  timer #(.cycle(32'd0))     u_t0  (.clk(clk), .rst(rst_v[4]), .cy(cy_o[4]), .cnt(cnt_o[4]));

  // Drive one edge; expectations come from the edge count since reset.
  task automatic step(input logic [c_n-1:0] r);
    exp_t e;
    rst_v = r;
    for (int d = 0; d < c_n; d++) begin
      if (r[d]) k[d] = 0;
      else      k[d] = k[d] + 1;
      e.d = d;
      e.c = 32'(k[d] % cyc_eff[d]);
      e.y = (k[d] != 0) && (k[d] % cyc_eff[d] == 0);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int s = 0; s < 3; s++) begin
      step('1);
      for (int i = 0; i < c_n; i++) begin
        e = q.pop_front();
        total++;
        if (cnt_o[e.d] !== e.c || cy_o[e.d] !== e.y) begin
          bad++;
          $display("FAIL reset dut%0d: cnt=%0d cy=%b want cnt=%0d cy=%b",
                   e.d, cnt_o[e.d], cy_o[e.d], e.c, e.y);
        end
      end
    end
  endtask

  task automatic test_count();
    exp_t e;
    int   pulses = 0;
    for (int s = 1; s <= 16; s++) begin
      step('0);
      for (int i = 0; i < c_n; i++) begin
        e = q.pop_front();
        total++;
        if (cnt_o[e.d] !== e.c || cy_o[e.d] !== e.y) begin
          bad++;
          $display("FAIL count dut%0d edge%0d: cnt=%0d cy=%b want cnt=%0d cy=%b",
                   e.d, s, cnt_o[e.d], cy_o[e.d], e.c, e.y);
        end
      end
      if (cy_o[0] === 1'b1) pulses++;
      total++;
      if ((cy_o[0] === 1'b1) !== (s == 5 || s == 10 || s == 15)) begin
        bad++;
        $display("FAIL pulse5 edge%0d: cy=%b", s, cy_o[0]);
      end
    end
    total++;
    if (pulses != 3) begin
      bad++;
      $display("FAIL pulse5_count: got %0d want 3", pulses);
    end
  endtask

  // dut0 is at cnt=1; advance to cnt=3, reset one edge, expect pulse 5 edges later.
  task automatic test_reset_mid();
    exp_t e;
    int   first = -1;
    for (int s = 0; s < 10; s++) begin
      step((s == 2) ? 5'b00001 : 5'b00000);
      for (int i = 0; i < c_n; i++) begin
        e = q.pop_front();
        total++;
        if (cnt_o[e.d] !== e.c || cy_o[e.d] !== e.y) begin
          bad++;
          $display("FAIL reset_mid dut%0d step%0d: cnt=%0d cy=%b want cnt=%0d cy=%b",
                   e.d, s, cnt_o[e.d], cy_o[e.d], e.c, e.y);
        end
      end
      if (s > 2 && first < 0 && cy_o[0] === 1'b1) first = s - 2;
    end
    total++;
    if (first != 5) begin
      bad++;
      $display("FAIL reset_mid_gap: pulse %0d edges after release, want 5", first);
    end
  endtask

  // Reset applied exactly on the wrap edge suppresses that pulse.
  task automatic test_reset_at_wrap();
    exp_t e;
    while (k[0] % 5 != 4) step('0);
    while (q.size() > 0) void'(q.pop_front());
    step(5'b00001);
    for (int i = 0; i < c_n; i++) begin
      e = q.pop_front();
      total++;
      if (cnt_o[e.d] !== e.c || cy_o[e.d] !== e.y) begin
        bad++;
        $display("FAIL reset_wrap dut%0d: cnt=%0d cy=%b want cnt=%0d cy=%b",
                 e.d, cnt_o[e.d], cy_o[e.d], e.c, e.y);
      end
    end
    total++;
    if (cy_o[0] !== 1'b0 || cnt_o[0] !== 32'd0) begin
      bad++;
      $display("FAIL reset_wrap_pulse: cy=%b cnt=%0d want 0/0", cy_o[0], cnt_o[0]);
    end
  endtask

  // cycle=1 and cycle=0: held high from edge 1, dropped by a single reset edge.
  task automatic test_cycle1();
    exp_t e;
    for (int s = 0; s < 6; s++) begin
      step((s == 3) ? 5'b10010 : 5'b00000);
      for (int i = 0; i < c_n; i++) begin
        e = q.pop_front();
        total++;
        if (cnt_o[e.d] !== e.c || cy_o[e.d] !== e.y) begin
          bad++;
          $display("FAIL cycle1 dut%0d step%0d: cnt=%0d cy=%b want cnt=%0d cy=%b",
                   e.d, s, cnt_o[e.d], cy_o[e.d], e.c, e.y);
        end
      end
      total++;
      if (cy_o[1] !== ((s == 3) ? 1'b0 : 1'b1) || cnt_o[1] !== 32'd0) begin
        bad++;
        $display("FAIL cycle1_direct step%0d: cy=%b cnt=%0d", s, cy_o[1], cnt_o[1]);
      end
    end
  endtask

  // Reset the long timer, then run just past one full period.
  task automatic test_long();
    exp_t        e;
    logic [31:0] mx = 0;
    int          pulses = 0;
    int          at = -1;
    step(5'b01000);
    for (int i = 0; i < c_n; i++) void'(q.pop_front());
    for (int s = 1; s <= 41672; s++) begin
      step('0);
      for (int i = 0; i < c_n; i++) begin
        e = q.pop_front();
        total++;
        if (cnt_o[e.d] !== e.c || cy_o[e.d] !== e.y) begin
          bad++;
          $display("FAIL long dut%0d edge%0d: cnt=%0d cy=%b want cnt=%0d cy=%b",
                   e.d, s, cnt_o[e.d], cy_o[e.d], e.c, e.y);
        end
      end
      if (cnt_o[3] > mx) mx = cnt_o[3];
      if (cy_o[3] === 1'b1) begin
        pulses++;
        at = s;
      end
    end
    total++;
    if (mx !== 32'd41666) begin
      bad++;
      $display("FAIL long_max: got %0d want 41666", mx);
    end
    total++;
    if (pulses != 1 || at != 41667) begin
      bad++;
      $display("FAIL long_pulse: count=%0d at=%0d want 1 at 41667", pulses, at);
    end
  endtask

  initial begin
    for (int d = 0; d < c_n; d++) k[d] = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_count();
    test_reset_mid();
    test_reset_at_wrap();
    test_cycle1();
    test_long();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
